// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding and FSM state type.
package alu_muldiv_pkg;

  localparam int unsigned OP_W = 2;

  // Operation select as presented on the op port.
  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  // Control states: idle, one shift step per cycle, sign fix-up/commit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage : alu_muldiv_pkg

// File: rtl/alu_muldiv.sv
// Iterative multiply / divide unit.
// Multiplies by shift-add and divides by restoring shift-subtract, one step
// per cycle on operand magnitudes, then applies signs in a final fix-up cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake (ready only while idle)
//   op, a, b          operation select and operands, captured at accept
//   flush             synchronous abort of the in-flight operation
//   busy              operation in flight (inverse of in_ready)
//   done              one-cycle pulse when hi/lo/div_zero update
//   hi, lo            product halves, or remainder / quotient
//   div_zero          last completed operation divided by zero
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned PW    = 2 * WIDTH;

  // Two's-complement negate when n is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hw_q, hw_d;      // working upper half / partial remainder
  logic [WIDTH-1:0]   lw_q, lw_d;      // working lower half / dividend-quotient
  logic [WIDTH-1:0]   opb_q, opb_d;    // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  op_e                op_c;
  logic               signed_op_c;
  logic               a_neg_c;
  logic               b_neg_c;
  logic [WIDTH-1:0]   a_mag_c;
  logic [WIDTH-1:0]   b_mag_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     shifted_c;
  logic               ge_c;
  logic [PW-1:0]      prod_c;

  // Operand sign/magnitude at the request boundary.
  always_comb begin
    op_c        = op_e'(op);
    signed_op_c = SIGNED_EN && ((op_c == OP_MULT) || (op_c == OP_DIV));
    a_neg_c     = signed_op_c && a[WIDTH-1];
    b_neg_c     = signed_op_c && b[WIDTH-1];
    a_mag_c     = neg_if(a_neg_c, a);
    b_mag_c     = neg_if(b_neg_c, b);
  end

  // One datapath step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum_c     = {1'b0, hw_q} + (lw_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    shifted_c = {hw_q, lw_q[WIDTH-1]};
    ge_c      = (shifted_c >= {1'b0, opb_q});
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hw_d      = hw_q;
    lw_d      = lw_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    prod_c    = {hw_q, lw_q};

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          state_d   = ST_ITER;
          cnt_d     = '0;
          hw_d      = '0;
          lw_d      = a_mag_c;
          opb_d     = b_mag_c;
          is_div_d  = op_c[1];
          neg_res_d = a_neg_c ^ b_neg_c;
          neg_rem_d = a_neg_c;
        end
      end

      ST_ITER: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          // All steps taken; the counter-terminal cycle hands over to fix-up.
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            hw_d = ge_c ? WIDTH'(shifted_c - {1'b0, opb_q}) : shifted_c[WIDTH-1:0];
            lw_d = {lw_q[WIDTH-2:0], ge_c};
          end else begin
            hw_d = sum_c[WIDTH:1];
            lw_d = {sum_c[0], lw_q[WIDTH-1:1]};
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // With a zero divisor every step subtracts nothing, so the
            // partial remainder ends as the dividend magnitude and the
            // dividend-sign rule restores the original a.
            hi_d = neg_if(neg_rem_q, hw_q);
            if (opb_q == '0) begin
              lo_d = '1;
              dz_d = 1'b1;
            end else begin
              lo_d = neg_if(neg_res_q, lw_q);
              dz_d = 1'b0;
            end
          end else begin
            prod_c = neg_res_q ? (~{hw_q, lw_q} + PW'(1)) : {hw_q, lw_q};
            hi_d   = prod_c[PW-1:WIDTH];
            lo_d   = prod_c[WIDTH-1:0];
            dz_d   = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hw_q      <= '0;
      lw_q      <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hw_q      <= hw_d;
      lw_q      <= lw_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign in_ready = ~busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule : alu_muldiv

// File: tb/tb_alu_muldiv.sv
// Randomized self-checking bench for alu_muldiv (WIDTH=32, signed enabled).
module tb_alu_muldiv;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 2;

  // Transaction modes.
  localparam int M_NORMAL  = 0;
  localparam int M_SPAM    = 1;  // keep presenting junk requests while busy
  localparam int M_FLUSH10 = 2;  // flush on accept+10
  localparam int M_FLUSHD  = 3;  // flush on the would-be done edge
  localparam int M_RESET   = 4;  // reset pulse at accept+5

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  int n_cmp = 0;
  int n_err = 0;

  // Last committed result as the reference sees it.
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;
  logic         ref_dz = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operation.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] mh, output logic [W-1:0] ml, output logic mz);
    longint      sx, sy, sq, sr;
    logic [63:0] ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    mz = 1'b0;
    case (o)
      2'd0: begin sq = sx * sy; {mh, ml} = 64'(sq); end
      2'd1: begin up = ux * uy; {mh, ml} = up; end
      default: begin
        if (y == '0) begin
          mh = x; ml = '1; mz = 1'b1;
        end else if (o == 2'd2) begin
          sq = sx / sy; sr = sx % sy;
          ml = W'(sq); mh = W'(sr);
        end else begin
          ml = W'(ux / uy); mh = W'(ux % uy);
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
    logic [W-1:0] mh, ml;
    logic         mz;
    bit           early;
    int           waited;
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = (mode == M_SPAM);
    a = $urandom; b = $urandom; op = 2'($urandom_range(3));
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    check("ready_after_accept", {63'd0, in_ready}, 64'd0);
    model(o, x, y, mh, ml, mz);
    early = 1'b0;
    for (int k = 1; k <= int'(LAT); k++) begin
      if (mode == M_FLUSH10 && k == 10) flush = 1'b1;
      if (mode == M_FLUSHD && k == int'(LAT)) flush = 1'b1;
      if (k == int'(LAT)) in_valid = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (mode == M_RESET && k == 5) begin
        rst_n = 1'b0;
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_flags", {60'd0, done, div_zero, busy, in_ready}, 64'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          if (done) early = 1'b1;
        end
        check("rst_no_done", {63'd0, early}, 64'd0);
        ref_hi = '0; ref_lo = '0; ref_dz = 1'b0;
        return;
      end
      if (mode == M_FLUSH10 && k == 10) begin
        check("flush_ready", {62'd0, in_ready, busy}, 64'b10);
        for (int j = 0; j < int'(LAT); j++) begin
          @(posedge clk); #1;
          if (done) early = 1'b1;
        end
        check("flush_no_done", {63'd0, early}, 64'd0);
        check("flush_hi_kept", 64'(hi), 64'(ref_hi));
        check("flush_lo_kept", 64'(lo), 64'(ref_lo));
        check("flush_dz_kept", {63'd0, div_zero}, {63'd0, ref_dz});
        return;
      end
      if (k < int'(LAT) && done) early = 1'b1;
    end
    check("done_early", {63'd0, early}, 64'd0);
    if (mode == M_FLUSHD) begin
      check("flushd_no_done", {63'd0, done}, 64'd0);
      check("flushd_hi_kept", 64'(hi), 64'(ref_hi));
      check("flushd_lo_kept", 64'(lo), 64'(ref_lo));
      check("flushd_ready", {63'd0, in_ready}, 64'd1);
    end else begin
      check("done_at_lat", {63'd0, done}, 64'd1);
      check("hi", 64'(hi), 64'(mh));
      check("lo", 64'(lo), 64'(ml));
      check("div_zero", {63'd0, div_zero}, {63'd0, mz});
      check("ready_after_done", {63'd0, in_ready}, 64'd1);
      ref_hi = mh; ref_lo = ml; ref_dz = mz;
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [5];
    corners[0] = '0;
    corners[1] = W'(1);
    corners[2] = '1;
    corners[3] = {1'b1, {(W-1){1'b0}}};
    corners[4] = {1'b0, {(W-1){1'b1}}};
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return W'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #2;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_flags", {60'd0, done, div_zero, busy, in_ready}, 64'b0001);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'd0, 32'hFFFF_FFFD, 32'd5, M_NORMAL);
    check("mult_neg3x5_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_neg3x5_lo", 64'(lo), 64'h0000_0000_FFFF_FFF1);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, M_NORMAL);
    check("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo", 64'(lo), 64'd1);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, M_NORMAL);
    check("div_neg7_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, M_NORMAL);
    check("div_min_lo", 64'(lo), 64'h0000_0000_8000_0000);
    check("div_min_hi", 64'(hi), 64'd0);
    issue(2'd3, 32'd100, 32'd0, M_NORMAL);
    check("divu_zero_dz", {63'd0, div_zero}, 64'd1);
    issue(2'd1, 32'd2, 32'd3, M_NORMAL);
    check("multu_2x3_lo", 64'(lo), 64'd6);

    // Flush during DIVU, then a normal request afterwards.
    issue(2'd3, 32'd1000, 32'd7, M_FLUSH10);
    issue(2'd3, 32'd1000, 32'd7, M_NORMAL);

    // Flush landing on the done edge.
    issue(2'd0, 32'd12345, 32'hFFFF_FF00, M_FLUSHD);

    // Flush while idle blocks the request.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    check("idle_flush_blocks", {63'd0, busy}, 64'd0);
    in_valid = 1'b0; flush = 1'b0;

    // Reset mid-operation.
    issue(2'd2, 32'hDEAD_BEEF, 32'd13, M_RESET);

    for (int i = 0; i < 50; i++) begin
      issue(2'($urandom_range(3)), pick(), pick(), ($urandom_range(1) == 0) ? M_NORMAL : M_SPAM);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_muldiv

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values are even integers 4..64.
REQ-002 Parameter SIGNED_EN, default 1; 0 makes MULT/DIV behave as MULTU/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present on op/a/b.
REQ-006 in_ready  output  1  unit idle, request will be accepted.
REQ-007 op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-008 a  input  WIDTH  multiplicand or dividend.
REQ-009 b  input  WIDTH  multiplier or divisor.
REQ-010 flush  input  1  synchronous abort of any in-flight operation (pipeline squash).
REQ-011 busy  output  1  operation in flight; equals ~in_ready.
REQ-012 done  output  1  one-cycle pulse, hi/lo just updated.
REQ-013 hi  output  WIDTH  product upper half or remainder.
REQ-014 lo  output  WIDTH  product lower half or quotient.
REQ-015 div_zero  output  1  last completed operation was divide with b==0; held until next done.

Function
REQ-016 Request accepted on a rising edge where in_valid & in_ready & ~flush; a, b, op captured then, later changes ignored.
REQ-017 FSM states IDLE, ITER, FIX; IDLE->ITER on accept, ITER->FIX after exactly WIDTH iteration cycles, FIX->IDLE after one cycle.
REQ-018 in_ready SHALL be 1 only in IDLE; requests presented while busy are not accepted and not queued.
REQ-019 Latency: done high, with hi/lo/div_zero updated, on the edge exactly WIDTH+2 edges after the accept edge; done low otherwise.
REQ-020 Multiply: one shift-add step per ITER cycle on operand magnitudes; full 2*WIDTH product, hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-021 Divide: one restoring shift-subtract step per ITER cycle on magnitudes; lo = quotient, hi = remainder.
REQ-022 Signed ops (SIGNED_EN=1): magnitudes taken at accept; in FIX, product and quotient negated iff operand signs differ, remainder takes dividend's sign.
REQ-023 Signed MIN / -1: lo = MIN (two's-complement wrap), hi = 0, no flag.
REQ-024 b==0 divide: same latency, lo = all ones, hi = a, div_zero=1; multiplies and nonzero divides set div_zero=0.
REQ-025 flush in ITER or FIX: next edge returns to IDLE, no done, hi/lo/div_zero unchanged; flush in IDLE blocks acceptance that cycle.
REQ-026 flush on the same edge that would assert done: flush wins, no done, hi/lo unchanged.
REQ-027 A new request may be accepted on the edge after done (back-to-back issue, one idle cycle between).

Reset
REQ-028 rst_n low forces, asynchronously: state IDLE, hi=0, lo=0, done=0, div_zero=0, busy=0, in_ready=1, iteration counter and working registers 0.
REQ-029 Reset mid-operation abandons it; no done is produced after rst_n rises.

Structure
REQ-030 Shared package alu_muldiv_pkg holds the op encoding constants and the FSM state type.
REQ-031 Iteration counter width is clog2(WIDTH)+1, derived inside the module.
REQ-032 No sub-module; sign handling, iteration datapath and FSM live in alu_muldiv.

Verification (WIDTH=32)
REQ-033 MULT a=0xFFFFFFFD (-3), b=5 -> done at accept+34 edges, hi=0xFFFFFFFF, lo=0xFFFFFFF1, div_zero=0.
REQ-034 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_zero=1; following MULTU 2*3 -> lo=6, div_zero=0.
REQ-037 Flush at accept+10 during DIVU -> no done, hi/lo keep prior values, in_ready=1 next cycle; new request accepted and completes normally.
REQ-038 rst_n pulsed low at accept+5 -> all outputs zero immediately, in_ready=1, no done observed within 40 cycles.
